// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, D = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
//
// state   | meaning
// S_IDLE  | waiting for operands, in_ready high
// S_SHIFT | one difference bit per cycle, d partially shifted
// S_DONE  | d/bout (and ovf) held, out_valid high until out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
    logic             w_ai;
    logic             w_bi;
    logic             w_di;
    logic             w_br_next;
    logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    // Full-subtractor cell on the current LSBs and the borrow flop.
    assign w_ai      = r_a_sh[0];
    assign w_bi      = r_b_sh[0];
    assign w_di      = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign d         = r_d;
    assign bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_d    <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_br   <= bin;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_d    <= {w_di, r_d[WIDTH-1:1]};
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    // Wrap to zero on the last bit so the counter never exceeds WIDTH-1.
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf  <= r_br ^ w_br_next;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 ops, backpressure, mid-op reset,
// optional ovf checks, and an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] d;
    logic       bout;
    logic       busy;

    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       out_valid4;
    logic       out_ready4 = 1'b1;
    logic [3:0] d4;
    logic       bout4;
    logic       busy4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       ovf4;
`endif

    int n_pass  = 0;
    int n_check = 0;
    int res_cnt4 = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .busy(busy)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .d(d4), .bout(bout4), .busy(busy4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always @(posedge clk) begin
        if (rst_n && out_valid4 && out_ready4) res_cnt4 <= res_cnt4 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept one operand set and wait for out_valid; checks handshake and latency.
    task automatic run_to_done(input logic [7:0] aa, input logic [7:0] bb, input logic bi);
        int n;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        a = aa; b = bb; bin = bi; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; bin = ~bi;
        chk("shift_in_ready", 32'(in_ready), 32'd0);
        chk("shift_busy", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd8);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [4:0] exp5;
        int         n;

        // Reset
        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic subtract 0x5A - 0x3C = 0x1E
        run_to_done(8'h5A, 8'h3C, 1'b0);
        chk("basic_d", 32'(d), 32'h1E);
        chk("basic_bout", 32'(bout), 32'd0);
        chk("basic_busy_done", 32'(busy), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("basic_ovf", 32'(ovf), 32'd0);
`endif
        release_out();

        // Wrap: 0 - 1
        run_to_done(8'h00, 8'h01, 1'b0);
        chk("wrap_d", 32'(d), 32'hFF);
        chk("wrap_bout", 32'(bout), 32'd1);
        release_out();

        // 0x10 - 0x0F - 1 = 0
        run_to_done(8'h10, 8'h0F, 1'b1);
        chk("bin_d", 32'(d), 32'h00);
        chk("bin_bout", 32'(bout), 32'd0);
        release_out();

        // a == b with bin = 1
        run_to_done(8'h33, 8'h33, 1'b1);
        chk("eq_bin_d", 32'(d), 32'hFF);
        chk("eq_bin_bout", 32'(bout), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("eq_bin_ovf", 32'(ovf), 32'd0);
`endif

        // Backpressure: hold DONE for 5 cycles while offering new operands
        for (int i = 0; i < 5; i++) begin
            a = 8'(8'h11 * (i + 1)); b = 8'h01; bin = 1'(i); in_valid = 1'(i + 1);
            step();
            chk("bp_d", 32'(d), 32'hFF);
            chk("bp_bout", 32'(bout), 32'd1);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out();

        // Signed-overflow cases
        run_to_done(8'h80, 8'h01, 1'b0);
        chk("ov1_d", 32'(d), 32'h7F);
        chk("ov1_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ov1_ovf", 32'(ovf), 32'd1);
`endif
        release_out();

        run_to_done(8'h7F, 8'hFF, 1'b0);
        chk("ov2_d", 32'(d), 32'h80);
        chk("ov2_bout", 32'(bout), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("ov2_ovf", 32'(ovf), 32'd1);
`endif
        release_out();

        // Reset during the 3rd SHIFT cycle
        a = 8'hF0; b = 8'h0F; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_d", 32'(d), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        chk("mid_rst_no_result", 32'(out_valid), 32'd0);

        run_to_done(8'h05, 8'h03, 1'b0);
        chk("post_rst_d", 32'(d), 32'h02);
        chk("post_rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("post_rst_ovf", 32'(ovf), 32'd0);
`endif
        release_out();

        // Exhaustive WIDTH=4 sweep, out_ready held high
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i >> 5); b4 = 4'(i >> 1); bin4 = 1'(i);
            exp5 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
            in_valid4 = 1'b1;
            n = 0;
            while (!in_ready4 && n < 10) begin
                step();
                n++;
            end
            step();
            in_valid4 = 1'b0;
            n = 0;
            while (!out_valid4 && n < 10) begin
                step();
                n++;
            end
            chk("w4_result", 32'({bout4, d4}), 32'(exp5));
            step();
        end
        step();
        chk("w4_result_count", 32'(res_cnt4), 32'd512);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = A - B - Bin, LSB first, one bit per clock, using a full-subtractor cell and a borrow flop.
- The sequential counterpart and inverse of the team's combinational full adder.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Used in area-constrained datapaths where a WIDTH-bit parallel subtractor is too costly.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
in_valid  input  1  operand set a/b/bin is valid
in_ready  output  1  block accepts operands; high only in IDLE
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  d/bout valid; high only in DONE
out_ready  input  1  consumer accepts result
d  output  WIDTH  difference, registered
bout  output  1  borrow-out, registered (1 = unsigned A < B + Bin)
busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock domain. Reset is synchronous, active-low (rst_n sampled on clk rising edge).
- Reset values, applied at the first edge with rst_n=0: state=IDLE, d=0, bout=0, borrow flop=0, bit counter=0, operand shift registers=0. Resulting outputs: out_valid=0, busy=0, in_ready=1.
- in_ready = (state==IDLE) && rst_n; it is 0 while rst_n is low.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a, b into shift registers; borrow flop <= bin; counter <= 0; go to SHIFT.
- State SHIFT, one result bit per cycle:
  - ai = a_sh[0], bi = b_sh[0], br = borrow flop.
  - di = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - d <= {di, d[WIDTH-1:1]}; a_sh and b_sh shift right by 1; borrow <= br_next; counter++.
  - When counter == WIDTH-1 (last bit): bout <= br_next; go to DONE.
  - in_valid is ignored while in SHIFT.
- State DONE:
  - out_valid=1; d and bout are held stable.
  - On out_ready: go to IDLE.
  - in_valid is ignored; a new operand can only be accepted after returning to IDLE.
- Latency: acceptance edge at cycle k gives out_valid=1 after edge k+WIDTH.
- Throughput, with out_ready held high: one operation per WIDTH+2 cycles (IDLE, WIDTH×SHIFT, DONE).
- Arithmetic:
  - Modulo 2^WIDTH: {bout, d} = {1'b0, A} - B - Bin in two's-complement sense.
  - bout is exactly the unsigned borrow.
- Boundary conditions:
  - Result wrap-around, e.g. 0 - 1 → all ones, bout=1.
  - bin=1 with a == b gives all ones, bout=1.
  - rst_n low in any state (including mid-SHIFT or DONE with out_valid high) aborts the operation: next cycle is IDLE, out_valid=0, d=0, and no result is delivered.
  - In SHIFT, d is partially shifted and must not be sampled.
  - Counter width is $clog2(WIDTH); it must never index past WIDTH-1.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - In the last SHIFT cycle, ovf <= br ^ br_next (borrow into MSB XOR borrow out of MSB): the signed two's-complement overflow of A - B - Bin.
  - ovf is valid and held with out_valid in DONE.
- Not defined: port ovf does not exist; no extra logic is generated.

Test Plan:
- Basic subtract, WIDTH=8: a=0x5A, b=0x3C, bin=0, in_valid for one cycle in IDLE → out_valid exactly 8 edges after acceptance, d=0x1E, bout=0; in_ready=0 and busy=1 until return to IDLE.
- Wrap/borrow: a=0x00, b=0x01, bin=0 → d=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → d=0x00, bout=0.
- Backpressure:
  - After an op completes, hold out_ready=0 for 5 cycles while toggling in_valid with new operands → d and bout unchanged, out_valid stays 1, in_ready stays 0, new operands not captured.
  - Assert out_ready → IDLE next cycle.
- Reset mid-op: start a=0xF0, b=0x0F; drive rst_n=0 during the 3rd SHIFT cycle → after that edge state=IDLE, out_valid=0, d=0, bout=0, in_ready=1. A following op a=0x05, b=0x03 → d=0x02.
- Overflow, with SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF → d=0x80, bout=1, ovf=1.
  - a=0x05, b=0x03 → ovf=0.
- Exhaustive sweep, WIDTH=4: all a, b, bin combinations (512) back-to-back with out_ready=1 → {bout, d} matches reference model A - B - Bin for every case, with no lost or duplicated results.
